// File: rtl/twoq_pkg.sv
// Shared types and default widths for the two-queue sampler and its bus/memory stage.
// Pure declarations; no latency or backpressure of its own.
package twoq_pkg;

  localparam int TWOQ_WIDTH   = 2;
  localparam int TWOQ_DWIDTH  = 4;
  localparam int TWOQ_LAT_MAX = 4;

  typedef struct packed {
    logic                    port;
    logic [TWOQ_WIDTH-1:0]   addr;
    logic [TWOQ_DWIDTH-1:0]  data;
  } rsp_t;

endpackage

// File: rtl/twoq_bus_mem_if.sv
// Queue-to-memory bus: per-queue request triplets plus grant in, read responses and status out.
// No flow control: requests are qualified by the registered grant, responses are fire-and-forget pulses.
interface twoq_bus_mem_if #(
  parameter int WIDTH  = twoq_pkg::TWOQ_WIDTH,
  parameter int DWIDTH = twoq_pkg::TWOQ_DWIDTH,
  parameter int CWIDTH = 8
);

  logic [1:0]        bus_gnt;
  logic [WIDTH-1:0]  addr0;
  logic [WIDTH-1:0]  addr1;
  logic [1:0]        validout;
  logic [1:0]        outisread;

  logic              rsp_valid;
  logic              rsp_port;
  logic [WIDTH-1:0]  rsp_addr;
  logic [DWIDTH-1:0] rsp_data;
  logic [CWIDTH-1:0] wr_count0;
  logic [CWIDTH-1:0] wr_count1;
  logic              proto_err;

  modport master (
    output bus_gnt, addr0, addr1, validout, outisread,
    input  rsp_valid, rsp_port, rsp_addr, rsp_data, wr_count0, wr_count1, proto_err
  );

  modport slave (
    input  bus_gnt, addr0, addr1, validout, outisread,
    output rsp_valid, rsp_port, rsp_addr, rsp_data, wr_count0, wr_count1, proto_err
  );

endinterface

// File: rtl/twoq_rsp_pipe.sv
// Fixed-latency valid+payload delay line; LATENCY register stages, first stage loads on in_vld.
// Never stalls; payload only advances behind a valid entry so the output holds its last response.
module twoq_rsp_pipe #(
  parameter int  LATENCY = 2,
  parameter type T       = logic
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_vld,
  input  T     in_dat,
  output logic out_vld,
  output T     out_dat
);

  logic [LATENCY-1:0] vld_q, vld_d;
  T                   dat_q [LATENCY];
  T                   dat_d [LATENCY];

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_vld;
    if (in_vld) dat_d[0] = in_dat;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/twoq_bus_mem.sv
// Memory model behind the two-queue bus: writes bump a per-address version word, reads return it tagged by queue.
// Read response LATENCY edges after acceptance; no backpressure, one acceptance per edge with port 0 winning.
module twoq_bus_mem
  import twoq_pkg::*;
#(
  parameter int WIDTH   = TWOQ_WIDTH,
  parameter int DWIDTH  = TWOQ_DWIDTH,
  parameter int LATENCY = 2,
  parameter int CWIDTH  = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  twoq_bus_mem_if.slave   bus
);

  localparam int DEPTH = 1 << WIDTH;

  typedef struct packed {
    logic              port;
    logic [WIDTH-1:0]  addr;
    logic [DWIDTH-1:0] data;
  } rsp_w_t;

  logic [1:0]        gnt_q, gnt_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [CWIDTH-1:0] wr_count0_q, wr_count0_d;
  logic [CWIDTH-1:0] wr_count1_q, wr_count1_d;
  logic              proto_err_q, proto_err_d;

  logic              acc0, acc1, acc, sel_rd;
  logic [WIDTH-1:0]  sel_addr;
  logic              rd_vld;
  rsp_w_t            rd_dat;
  logic              rsp_vld;
  rsp_w_t            rsp_dat;

  // Port 1 is only eligible when port 0 holds no grant, so a double grant drops port 1.
  always_comb begin
    acc0     = gnt_q[0] & bus.validout[0];
    acc1     = (gnt_q == 2'b10) & bus.validout[1];
    acc      = acc0 | acc1;
    sel_addr = acc1 ? bus.addr1 : bus.addr0;
    sel_rd   = acc1 ? bus.outisread[1] : bus.outisread[0];
    rd_vld   = acc & sel_rd;
    rd_dat.port = acc1;
    rd_dat.addr = sel_addr;
    rd_dat.data = mem_q[sel_addr];
  end

  always_comb begin
    gnt_d       = bus.bus_gnt;
    mem_d       = mem_q;
    wr_count0_d = wr_count0_q;
    wr_count1_d = wr_count1_q;
    proto_err_d = proto_err_q | (gnt_q == 2'b11);
    if (acc && !sel_rd) begin
      mem_d[sel_addr] = mem_q[sel_addr] + 1'b1;
      if (acc0 && wr_count0_q != '1) wr_count0_d = wr_count0_q + 1'b1;
      if (acc1 && wr_count1_q != '1) wr_count1_d = wr_count1_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_count0_q <= '0;
      wr_count1_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      mem_q       <= mem_d;
      wr_count0_q <= wr_count0_d;
      wr_count1_q <= wr_count1_d;
      proto_err_q <= proto_err_d;
    end
  end

  twoq_rsp_pipe #(
    .LATENCY (LATENCY),
    .T       (rsp_w_t)
  ) u_rsp_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .in_vld  (rd_vld),
    .in_dat  (rd_dat),
    .out_vld (rsp_vld),
    .out_dat (rsp_dat)
  );

  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_port  = rsp_dat.port;
  assign bus.rsp_addr  = rsp_dat.addr;
  assign bus.rsp_data  = rsp_dat.data;
  assign bus.wr_count0 = wr_count0_q;
  assign bus.wr_count1 = wr_count1_q;
  assign bus.proto_err = proto_err_q;

  // A granted, valid request must carry a known direction.
  a_isread_known0: assert property (@(posedge clock) disable iff (!reset_n)
    (gnt_q[0] && bus.validout[0]) |-> !$isunknown(bus.outisread[0]));
  a_isread_known1: assert property (@(posedge clock) disable iff (!reset_n)
    (gnt_q[1] && bus.validout[1]) |-> !$isunknown(bus.outisread[1]));

endmodule
